// File: rtl/serial_arbiter.sv
// serial_arbiter: round-robin arbiter that serializes one requester's frame into a shared detector.
module serial_arbiter #(
  parameter int FRAME_LEN = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3:0]             req,
  input  logic [4*FRAME_LEN-1:0] frame_data,
  input  logic [1:0]             det_out,
  output logic                   det_in,
  output logic                   det_rst,
  output logic [3:0]             gnt,
  output logic [3:0]             done,
  output logic [1:0]             result,
  output logic                   busy
);
  localparam int CW = $clog2(FRAME_LEN);
  if (FRAME_LEN < 2 || FRAME_LEN > 16) begin : g_bad_len
    $error("FRAME_LEN must be within 2..16");
  end
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, CAPTURE} state_t;
  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [FRAME_LEN-1:0] sr_q, sr_d;
  logic [1:0]           last_gnt_q, last_gnt_d;
  logic [3:0]           gnt_q, gnt_d, done_q, done_d;
  logic [1:0]           result_q, result_d;
  logic                 det_rst_q, det_rst_d;
  logic [1:0]           win, idx;
  logic                 found;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sr_q       <= '0;
      last_gnt_q <= 2'd3;
      gnt_q      <= '0;
      done_q     <= '0;
      result_q   <= '0;
      det_rst_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      last_gnt_q <= last_gnt_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      result_q   <= result_d;
      det_rst_q  <= det_rst_d;
    end
  end
  // search starts one past the previous winner, so a held request yields to others
  always_comb begin
    win   = last_gnt_q;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_gnt_q + 2'(k);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    last_gnt_d = last_gnt_q;
    case (state_q)
      IDLE: begin
        state_d    = |req ? LOAD : IDLE;
        last_gnt_d = |req ? win : last_gnt_q;
      end
      LOAD: begin
        state_d = SHIFT;
        cnt_d   = '0;
        sr_d    = frame_data[int'(last_gnt_q)*FRAME_LEN +: FRAME_LEN];
      end
      SHIFT: begin
        sr_d    = sr_q << 1;
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == CW'(FRAME_LEN-1)) ? CAPTURE : SHIFT;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    gnt_d     = (state_q == IDLE && |req) ? 4'b0001 << win : (state_q == CAPTURE ? 4'b0 : gnt_q);
    done_d    = (state_q == CAPTURE) ? gnt_q : 4'b0;
    result_d  = (state_q == CAPTURE) ? det_out : result_q;
    det_rst_d = (state_d == LOAD);
    det_in    = (state_q == SHIFT) && sr_q[FRAME_LEN-1];
    busy      = (state_q != IDLE);
  end
  assign det_rst = det_rst_q;
  assign gnt     = gnt_q;
  assign done    = done_q;
  assign result  = result_q;
endmodule

// File: tb/tb_serial_arbiter.sv
// tb_serial_arbiter: directed checks of grant order, frame serialization, done timing and reset.
module tb_serial_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] frame_data;
  logic [1:0]  det_out;
  logic        det_in, det_rst, busy;
  logic [3:0]  gnt, done;
  logic [1:0]  result;
  int checks = 0;
  int failures = 0;

  serial_arbiter #(.FRAME_LEN(8)) dut (
    .clk(clk), .rst(rst), .req(req), .frame_data(frame_data), .det_out(det_out),
    .det_in(det_in), .det_rst(det_rst), .gnt(gnt), .done(done), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // called right after the grant edge; ends right after the done edge
  task automatic frame(input logic [3:0] g, input logic [7:0] f, input logic [1:0] d);
    logic [31:0] saved;
    saved = frame_data;
    chk("load_gnt", gnt, g);
    chk("load_busy", busy, 1);
    chk("load_det_rst", det_rst, 1);
    chk("load_det_in", det_in, 0);
    for (int i = 0; i < 8; i++) begin
      tick;
      chk("shift_det_in", det_in, f[7-i]);
      chk("shift_gnt", gnt, g);
      if (i == 0) begin
        chk("shift_det_rst", det_rst, 0);
        frame_data = ~saved;
      end
    end
    tick;
    chk("cap_gnt", gnt, g);
    chk("cap_det_in", det_in, 0);
    chk("cap_done", done, 0);
    det_out = d;
    frame_data = saved;
    tick;
    chk("done", done, g);
    chk("done_gnt", gnt, 0);
    chk("result", result, d);
    chk("done_busy", busy, 0);
  endtask

  initial begin
    rst = 1'b0;
    req = 4'b0;
    frame_data = {8'hC3, 8'h5A, 8'hA5, 8'h38};
    det_out = 2'b00;
    tick;
    tick;
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_det_rst", det_rst, 1);
    chk("rst_busy", busy, 0);
    chk("rst_det_in", det_in, 0);
    rst = 1'b1;
    tick;
    chk("rel_det_rst", det_rst, 0);
    chk("rel_busy", busy, 0);
    // single requester, frame 0x38
    req = 4'b0001;
    tick;
    req = 4'b0;
    frame(4'b0001, 8'h38, 2'b10);
    tick;
    chk("idle_done", done, 0);
    chk("idle_gnt", gnt, 0);
    // all requesting: order 0,1,2,3,0 with one IDLE cycle between frames
    rst = 1'b0;
    tick;
    rst = 1'b1;
    req = 4'b1111;
    tick;
    frame(4'b0001, 8'h38, 2'b01);
    tick;
    frame(4'b0010, 8'hA5, 2'b10);
    tick;
    frame(4'b0100, 8'h5A, 2'b11);
    tick;
    frame(4'b1000, 8'hC3, 2'b00);
    tick;
    frame(4'b0001, 8'h38, 2'b01);
    req = 4'b0;
    tick;
    chk("rr_end_busy", busy, 0);
    // one-cycle pulse on req2 still runs a full frame
    req = 4'b0100;
    tick;
    req = 4'b0;
    frame(4'b0100, 8'h5A, 2'b11);
    tick;
    chk("pulse_end_busy", busy, 0);
    // reset during shift bit 4 aborts the frame
    req = 4'b0010;
    tick;
    req = 4'b0;
    chk("abort_gnt", gnt, 4'b0010);
    for (int i = 0; i < 5; i++) tick;
    chk("abort_busy_pre", busy, 1);
    rst = 1'b0;
    tick;
    chk("abort_gnt_post", gnt, 0);
    chk("abort_busy_post", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_result", result, 0);
    chk("abort_det_rst", det_rst, 1);
    rst = 1'b1;
    req = 4'b1111;
    tick;
    req = 4'b0;
    frame(4'b0001, 8'h38, 2'b00);
    // lone held requester is regranted after one IDLE cycle
    req = 4'b0100;
    tick;
    frame(4'b0100, 8'h5A, 2'b10);
    tick;
    req = 4'b0101;
    frame(4'b0100, 8'h5A, 2'b01);
    // held requester yields to the other active requester
    tick;
    req = 4'b0;
    frame(4'b0001, 8'h38, 2'b11);
    tick;
    chk("final_busy", busy, 0);
    chk("final_done", done, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/serial_arbiter.md
SERIAL_ARBITER -- requirements
Module: serial_arbiter

Interface
REQ-001 Parameter FRAME_LEN, default 8, sets the number of bits per frame, MSB first; the legal range is 2..16.
REQ-002 clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-low.
REQ-004 req  input  4  request lines; req[i] high means requester i has a frame pending.
REQ-005 frame_data  input  4*FRAME_LEN  packed frames; requester i occupies bits [FRAME_LEN*i+FRAME_LEN-1 : FRAME_LEN*i].
REQ-006 det_out  input  2  2-bit status returned by the shared serial detector.
REQ-007 det_in  output  1  serial bit driven to the shared detector's in port.
REQ-008 det_rst  output  1  active-high clear to the shared detector.
REQ-009 gnt  output  4  one-hot grant; all zeros when no frame is in progress.
REQ-010 done  output  4  one-hot completion pulse to the granted requester.
REQ-011 result  output  2  captured det_out value for the most recent frame.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 The block SHALL implement a four-state FSM: IDLE, LOAD, SHIFT and CAPTURE.
REQ-014 IDLE: with any req bit high at an edge, the block SHALL select a winner round-robin and go to LOAD; otherwise it SHALL stay in IDLE.
REQ-015 Round-robin priority SHALL start at index (last_gnt+1) mod 4 and ascend cyclically; last_gnt updates to the winner.
REQ-016 LOAD lasts one cycle: gnt is the winner's one-hot, det_rst=1, det_in=0; the winner's frame SHALL be latched into a FRAME_LEN-bit shift register.
REQ-017 SHIFT lasts exactly FRAME_LEN cycles: det_in = shift-register MSB, shifting left once per cycle, det_rst=0, gnt held.
REQ-018 CAPTURE lasts one cycle, gnt held, det_in=0; at its closing edge result<=det_out, done<=gnt, gnt<=0, and the state returns to IDLE.
REQ-019 done SHALL be high for exactly one cycle, FRAME_LEN+2 edges after the edge at which the request was granted in IDLE.
REQ-020 result SHALL hold its value until the next CAPTURE.
REQ-021 frame_data SHALL be sampled only in LOAD; later changes do not affect the frame in flight.
REQ-022 If req[i] drops while i is granted, the frame SHALL still complete and done[i] SHALL still pulse.
REQ-023 A new grant may be issued in the same cycle that done is high; frames are therefore back-to-back with a 1-cycle IDLE gap.
REQ-024 A requester holding req high after done SHALL not be regranted ahead of other active requesters.
REQ-025 A requester may be regranted immediately if it is the only active requester.
REQ-026 gnt and done SHALL always be one-hot or zero; busy SHALL equal (state != IDLE).

Reset
REQ-027 While rst=0 at an edge, the block SHALL go to IDLE and set gnt=0, done=0, result=2'b00, det_in=0, det_rst=1, busy=0, shift register=0, last_gnt=3.
REQ-028 Reset applied mid-frame SHALL abort the frame, assert no done, and apply the same values as REQ-027.
REQ-029 After reset, the first grant with all req high SHALL go to requester 0.
REQ-030 det_rst SHALL return to 0 on the first edge with rst=1, unless the block is entering LOAD.

Verification
REQ-031 Reset, then req=4'b0001 with frame0=8'b00111000 -> gnt=0001 for 10 cycles; det_in sequence 0,0,1,1,1,0,0,0; done=0001 at edge 10; result equals det_out sampled at the end of CAPTURE.
REQ-032 req=4'b1111 held high -> grant order 0,1,2,3,0; each done has a 1-cycle gap before the next gnt.
REQ-033 req2 pulses for 1 cycle only while IDLE -> the full frame still runs; done=0100 after 10 edges.
REQ-034 frame_data changes during SHIFT -> the det_in sequence matches the value latched in LOAD.
REQ-035 rst=0 during SHIFT bit 4 -> next cycle gnt=0, busy=0, done stays 0, result=00; the next grant goes to requester 0.
REQ-036 req=4'b0100 only, held after done -> regranted to 2 with no extra idle cycles beyond the 1-cycle IDLE.
